// File: rtl/stack_seq_ctrl.sv
// Fetch/issue sequencer for the stack processor: walks the instruction ROM, issues push/ALU ops
// to the stack datapath over valid/ready, and stops on halt or on a stack/PC fault.
module stack_seq_ctrl #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 16,
    parameter int CNT_W       = 16,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    input  logic [8:0]         inst,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic               issue_push,
    output logic [7:0]         issue_imm,
    output logic [7:0]         issue_func,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [DEPTH_W-1:0] depth,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [8:0]         HALT_INST = 9'h1FF;
    localparam logic [PC_W-1:0]    PC_LAST   = {PC_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_OVF   = 2'b01;
    localparam logic [1:0] CODE_UNF   = 2'b10;
    localparam logic [1:0] CODE_PCEND = 2'b11;

    function automatic logic is_halt(input logic [8:0] ins);
        return ins == HALT_INST;
    endfunction

    function automatic logic is_alu(input logic [8:0] ins);
        return ins[8] && (ins != HALT_INST);
    endfunction

    state_t               state_r, state_n;
    logic [PC_W-1:0]      pc_r, pc_n;
    logic [8:0]           ir_r, ir_n;
    logic [DEPTH_W-1:0]   depth_r, depth_n;
    logic [CNT_W-1:0]     retired_r, retired_n;
    logic [1:0]           err_code_r, err_code_n;

    logic halt_s, push_s, alu_s, ovf_s, unf_s, issue_ok_s;

    // Decode the held instruction and evaluate stack checks against pre-op depth.
    always_comb begin
        halt_s     = is_halt(ir_r);
        push_s     = ~ir_r[8];
        alu_s      = is_alu(ir_r);
        ovf_s      = push_s && (depth_r == DEPTH_MAX);
        unf_s      = alu_s && (depth_r < DEPTH_TWO);
        issue_ok_s = (state_r == ISSUE) && !halt_s && !ovf_s && !unf_s;
    end

    // Next-state and next-register computation for the sequencer.
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        ir_n       = ir_r;
        depth_n    = depth_r;
        retired_n  = retired_r;
        err_code_n = err_code_r;
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    pc_n       = {PC_W{1'b0}};
                    depth_n    = {DEPTH_W{1'b0}};
                    retired_n  = {CNT_W{1'b0}};
                    err_code_n = CODE_NONE;
                    state_n    = FETCH;
                end else begin
                    state_n = state_r;
                end
            end
            FETCH: begin
                ir_n    = inst;
                state_n = ISSUE;
            end
            ISSUE: begin
                if (halt_s) begin
                    state_n = DONE;
                end else if (ovf_s) begin
                    err_code_n = CODE_OVF;
                    state_n    = ERROR;
                end else if (unf_s) begin
                    err_code_n = CODE_UNF;
                    state_n    = ERROR;
                end else if (issue_ready) begin
                    // An ALU op pops two and pushes one, so net depth change is -1.
                    if (push_s) begin
                        depth_n = depth_r + DEPTH_W'(1);
                    end else begin
                        depth_n = depth_r - DEPTH_W'(1);
                    end
                    if (retired_r != CNT_MAX) begin
                        retired_n = retired_r + CNT_W'(1);
                    end else begin
                        retired_n = retired_r;
                    end
                    if (pc_r == PC_LAST) begin
                        err_code_n = CODE_PCEND;
                        state_n    = ERROR;
                    end else begin
                        pc_n    = pc_r + PC_W'(1);
                        state_n = FETCH;
                    end
                end else begin
                    state_n = ISSUE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            pc_r       <= {PC_W{1'b0}};
            ir_r       <= 9'h000;
            depth_r    <= {DEPTH_W{1'b0}};
            retired_r  <= {CNT_W{1'b0}};
            err_code_r <= CODE_NONE;
        end else begin
            state_r    <= state_n;
            pc_r       <= pc_n;
            ir_r       <= ir_n;
            depth_r    <= depth_n;
            retired_r  <= retired_n;
            err_code_r <= err_code_n;
        end
    end

    // Every output is a register or a pure decode of registers; none looks at issue_ready.
    assign pc          = pc_r;
    assign issue_valid = issue_ok_s;
    assign issue_push  = push_s;
    assign issue_imm   = ir_r[7:0];
    assign issue_func  = ir_r[7:0];
    assign busy        = (state_r == FETCH) || (state_r == ISSUE);
    assign done        = (state_r == DONE);
    assign err         = (state_r == ERROR);
    assign err_code    = err_code_r;
    assign depth       = depth_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Testbench for stack_seq_ctrl: directed scenarios plus random programs checked against a
// program-level reference model that simply executes the ROM.
module tb_stack_seq_ctrl;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       start_a, ready_a, valid_a, push_a, busy_a, done_a, err_a;
    logic [7:0] pc_a, imm_a, func_a;
    logic [8:0] inst_a;
    logic [1:0] code_a;
    logic [4:0] depth_a;
    logic [15:0] ret_a;
    logic [8:0] rom_a [256];
    assign inst_a = rom_a[pc_a];

    stack_seq_ctrl dut_a (
        .CLK(clk), .reset(rst), .start(start_a), .pc(pc_a), .inst(inst_a),
        .issue_valid(valid_a), .issue_ready(ready_a), .issue_push(push_a),
        .issue_imm(imm_a), .issue_func(func_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_code(code_a), .depth(depth_a), .retired(ret_a)
    );

    // Instance B: STACK_DEPTH=4
    logic       start_b, ready_b, valid_b, push_b, busy_b, done_b, err_b;
    logic [7:0] pc_b, imm_b, func_b;
    logic [8:0] inst_b;
    logic [1:0] code_b;
    logic [2:0] depth_b;
    logic [15:0] ret_b;
    logic [8:0] rom_b [256];
    assign inst_b = rom_b[pc_b];

    stack_seq_ctrl #(.STACK_DEPTH(4)) dut_b (
        .CLK(clk), .reset(rst), .start(start_b), .pc(pc_b), .inst(inst_b),
        .issue_valid(valid_b), .issue_ready(ready_b), .issue_push(push_b),
        .issue_imm(imm_b), .issue_func(func_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_code(code_b), .depth(depth_b), .retired(ret_b)
    );

    // Instance C: PC_W=2
    logic       start_c, ready_c, valid_c, push_c, busy_c, done_c, err_c;
    logic [1:0] pc_c;
    logic [7:0] imm_c, func_c;
    logic [8:0] inst_c;
    logic [1:0] code_c;
    logic [4:0] depth_c;
    logic [15:0] ret_c;
    logic [8:0] rom_c [4];
    assign inst_c = rom_c[pc_c];

    stack_seq_ctrl #(.PC_W(2)) dut_c (
        .CLK(clk), .reset(rst), .start(start_c), .pc(pc_c), .inst(inst_c),
        .issue_valid(valid_c), .issue_ready(ready_c), .issue_push(push_c),
        .issue_imm(imm_c), .issue_func(func_c), .busy(busy_c), .done(done_c),
        .err(err_c), .err_code(code_c), .depth(depth_c), .retired(ret_c)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: executes the program and records the accepted op stream.
    logic [8:0] mrom [256];
    int m_cap, m_last, m_done, m_code, m_pc, m_depth, m_ret;
    logic [8:0] exp_q [$];
    int         expd_q [$];

    task automatic model();
        int p, d;
        logic [8:0] ins;
        p = 0; d = 0; m_ret = 0; m_done = 0; m_code = 0;
        exp_q.delete(); expd_q.delete();
        while (1) begin
            ins = mrom[p];
            if (ins == 9'h1FF) begin m_done = 1; break; end
            if (ins[8] == 1'b0 && d == m_cap) begin m_code = 1; break; end
            if (ins[8] == 1'b1 && d < 2) begin m_code = 2; break; end
            exp_q.push_back(ins);
            expd_q.push_back(d);
            d = ins[8] ? d - 1 : d + 1;
            m_ret++;
            if (p == m_last) begin m_code = 3; break; end
            p++;
        end
        m_pc = p;
        m_depth = d;
    endtask

    task automatic load_prog1();
        for (int i = 0; i < 256; i++) rom_a[i] = 9'h1FF;
        for (int i = 0; i < 7; i++) rom_a[i] = 9'(i);
        rom_a[7] = 9'h100;
        rom_a[8] = 9'h1FF;
    endtask

    int seen_valid_a;

    // mode 0: ready=1; mode 1: random ready; mode 2: stall 3 cycles on push 5
    task automatic run_a(input int mode, input int budget, output int cyc);
        int hs, stall_cnt;
        logic prev_stall, pv, pp;
        logic [7:0] pimm, ppc;
        logic [8:0] e;
        int ed;
        for (int i = 0; i < 256; i++) mrom[i] = rom_a[i];
        m_cap = 16; m_last = 255;
        model();
        hs = 0; stall_cnt = 0; prev_stall = 1'b0; seen_valid_a = 0;
        pv = 1'b0; pp = 1'b0; pimm = 8'h00; ppc = 8'h00;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        cyc = 0;
        while (busy_a && cyc < budget) begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, valid_a}, {31'd0, pv});
                chk("hold_push", {31'd0, push_a}, {31'd0, pp});
                chk("hold_imm", {24'd0, imm_a}, {24'd0, pimm});
                chk("hold_pc", {24'd0, pc_a}, {24'd0, ppc});
            end
            case (mode)
                1: ready_a = ($urandom_range(0, 9) < 7);
                2: begin
                    if (valid_a && push_a && imm_a == 8'h05 && stall_cnt < 3) begin
                        ready_a = 1'b0;
                        stall_cnt++;
                        chk("stall_pc", {24'd0, pc_a}, 32'd5);
                    end else begin
                        ready_a = 1'b1;
                    end
                end
                default: ready_a = 1'b1;
            endcase
            if (valid_a) seen_valid_a = 1;
            if (valid_a && ready_a) begin
                if (exp_q.size() == 0) begin
                    chk("extra_issue", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    ed = expd_q.pop_front();
                    chk("op_push", {31'd0, push_a}, {31'd0, ~e[8]});
                    chk(e[8] ? "op_func" : "op_imm", {24'd0, e[8] ? func_a : imm_a}, {24'd0, e[7:0]});
                    chk("op_depth", {27'd0, depth_a}, 32'(ed));
                end
                hs++;
            end
            prev_stall = valid_a && !ready_a;
            pv = valid_a; pp = push_a; pimm = imm_a; ppc = pc_a;
            @(negedge clk);
            cyc++;
        end
        chk("a_timeout", {31'd0, busy_a}, 32'd0);
        chk("a_done", {31'd0, done_a}, 32'(m_done));
        chk("a_err", {31'd0, err_a}, {31'd0, m_code != 0});
        chk("a_code", {30'd0, code_a}, 32'(m_code));
        chk("a_pc", {24'd0, pc_a}, 32'(m_pc));
        chk("a_depth", {27'd0, depth_a}, 32'(m_depth));
        chk("a_retired", {16'd0, ret_a}, 32'(m_ret));
        chk("a_handshakes", 32'(hs), 32'(m_ret));
        if (mode == 2) chk("stall_count", 32'(stall_cnt), 32'd3);
        ready_a = 1'b1;
    endtask

    int cyc;
    int hs_b, hs_c, n;
    logic sawpc4;

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
        for (int i = 0; i < 256; i++) begin rom_a[i] = 9'h1FF; rom_b[i] = 9'h1FF; end
        for (int i = 0; i < 4; i++) rom_c[i] = 9'h1FF;
        repeat (2) @(negedge clk);
        chk("rst_pc", {24'd0, pc_a}, 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_code", {30'd0, code_a}, 32'd0);
        chk("rst_depth", {27'd0, depth_a}, 32'd0);
        chk("rst_retired", {16'd0, ret_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: push 0..6, add, halt
        load_prog1();
        run_a(0, 200, cyc);
        chk("t1_latency", 32'(cyc), 32'd18);
        chk("t1_depth", {27'd0, depth_a}, 32'd6);
        chk("t1_retired", {16'd0, ret_a}, 32'd8);
        chk("t1_pc", {24'd0, pc_a}, 32'd8);

        // Test 2: same ROM on a 4-deep stack
        for (int i = 0; i < 256; i++) rom_b[i] = rom_a[i];
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 0; hs_b = 0; sawpc4 = 1'b0;
        while (busy_b && n < 200) begin
            if (valid_b) hs_b++;
            if (valid_b && pc_b == 8'd4) sawpc4 = 1'b1;
            @(negedge clk); n++;
        end
        chk("t2_err", {31'd0, err_b}, 32'd1);
        chk("t2_code", {30'd0, code_b}, 32'd1);
        chk("t2_pc", {24'd0, pc_b}, 32'd4);
        chk("t2_depth", {29'd0, depth_b}, 32'd4);
        chk("t2_retired", {16'd0, ret_b}, 32'd4);
        chk("t2_issues", 32'(hs_b), 32'd4);
        chk("t2_no_fifth", {31'd0, sawpc4}, 32'd0);

        // Test 3: add with empty stack
        for (int i = 0; i < 256; i++) rom_a[i] = 9'h1FF;
        rom_a[0] = 9'h100;
        run_a(0, 200, cyc);
        chk("t3_err", {31'd0, err_a}, 32'd1);
        chk("t3_code", {30'd0, code_a}, 32'd2);
        chk("t3_pc", {24'd0, pc_a}, 32'd0);
        chk("t3_no_valid", 32'(seen_valid_a), 32'd0);

        // Test 4: backpressure on push 5
        load_prog1();
        run_a(2, 200, cyc);
        chk("t4_depth", {27'd0, depth_a}, 32'd6);
        chk("t4_latency", 32'(cyc), 32'd21);

        // Test 5: start ignored while busy, reset mid-ISSUE
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (4) @(negedge clk);
        start_a = 1'b1; ready_a = 1'b0;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'd0, busy_a}, 32'd1);
        chk("t5_pc", {24'd0, pc_a}, 32'd2);
        chk("t5_valid", {31'd0, valid_a}, 32'd1);
        chk("t5_retired", {16'd0, ret_a}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, valid_a}, 32'd0);
        chk("t5_rst_pc", {24'd0, pc_a}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("t5_rst_depth", {27'd0, depth_a}, 32'd0);
        @(negedge clk); rst = 1'b0; ready_a = 1'b1;
        run_a(0, 200, cyc);
        chk("t5_rerun_latency", 32'(cyc), 32'd18);
        chk("t5_rerun_retired", {16'd0, ret_a}, 32'd8);

        // Test 6: PC runs off the end of a 4-word program space
        for (int i = 0; i < 4; i++) rom_c[i] = 9'(8'h10 + i);
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        n = 0; hs_c = 0;
        while (busy_c && n < 100) begin
            if (valid_c) hs_c++;
            @(negedge clk); n++;
        end
        chk("t6_err", {31'd0, err_c}, 32'd1);
        chk("t6_code", {30'd0, code_c}, 32'd3);
        chk("t6_pc", {30'd0, pc_c}, 32'd3);
        chk("t6_retired", {16'd0, ret_c}, 32'd4);
        chk("t6_depth", {27'd0, depth_c}, 32'd4);
        chk("t6_issues", 32'(hs_c), 32'd4);

        // Random programs against the reference model
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 256; i++) begin
                n = $urandom_range(0, 99);
                if (n < 58)      rom_a[i] = {1'b0, 8'($urandom_range(0, 255))};
                else if (n < 97) rom_a[i] = {1'b1, 8'($urandom_range(0, 254))};
                else             rom_a[i] = 9'h1FF;
            end
            if (k == 9) for (int i = 0; i < 256; i++) rom_a[i] = (i % 2 == 0) ? 9'h011 : 9'h122;
            if (k == 9) begin rom_a[0] = 9'h001; rom_a[1] = 9'h002; end
            run_a(k % 2, 5000, cyc);
            if (k % 2 == 0) chk("rnd_latency", 32'(cyc), 32'((m_code == 3) ? 2 * m_ret : 2 * m_ret + 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
